// File: rtl/vote_tally_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vote_tally_controller                                                    |
// | One vote per arming, saturating per-candidate tallies, LED result cycler |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module vote_tally_controller #(
  parameter int NUM_CAND = 5,
  parameter int CNT_W    = 8,
  parameter int DWELL    = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode,
  input  logic                arm,
  input  logic [NUM_CAND-1:0] cand_valid,
  output logic                voter_ready,
  output logic                vote_ack,
  output logic                sat,
  output logic [2:0]          disp_idx,
  output logic [7:0]          LEDs
);

  localparam int               DW_W      = $clog2(DWELL);
  localparam logic [CNT_W-1:0] TALLY_MAX = '1;

  typedef enum logic [1:0] {
    S_LOCKED = 2'd0,
    S_ARMED  = 2'd1,
    S_ACK    = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] tally     [NUM_CAND];
  logic [CNT_W-1:0] tally_nxt [NUM_CAND];
  logic [DW_W-1:0]  dwell;
  logic [DW_W-1:0]  dwell_nxt;
  logic [2:0]       idx_nxt;
  logic [2:0]       vote_idx;
  logic [CNT_W-1:0] led_sel;
  logic             single_press;
  logic             do_vote;
  logic             sat_hit;

  // A press of two or more buttons in the same cycle is ambiguous and dropped.
  assign single_press = ($countones(cand_valid) == 1);
  assign do_vote      = (state == S_ARMED) && !mode && single_press;

  always_comb begin
    vote_idx = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (cand_valid[i]) vote_idx = 3'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOCKED: begin
        if (mode)     state_nxt = S_RESULT;
        else if (arm) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (mode)              state_nxt = S_RESULT;
        else if (single_press) state_nxt = S_ACK;
      end
      S_ACK:    state_nxt = S_LOCKED;
      S_RESULT: begin
        if (!mode) state_nxt = S_LOCKED;
      end
      default:  state_nxt = S_LOCKED;
    endcase
  end

  // Tallies hold at all-ones instead of wrapping; reaching all-ones flags sat.
  always_comb begin
    sat_hit = 1'b0;
    for (int i = 0; i < NUM_CAND; i++) begin
      tally_nxt[i] = tally[i];
      if (do_vote && (vote_idx == 3'(i))) begin
        if (tally[i] != TALLY_MAX) tally_nxt[i] = tally[i] + CNT_W'(1);
        if (tally_nxt[i] == TALLY_MAX) sat_hit = 1'b1;
      end
    end
  end

  // Entering RESULT always restarts the display at candidate 0.
  always_comb begin
    dwell_nxt = '0;
    idx_nxt   = '0;
    if ((state == S_RESULT) && (state_nxt == S_RESULT)) begin
      if (dwell == DW_W'(DWELL - 1)) begin
        dwell_nxt = '0;
        idx_nxt   = (disp_idx == 3'(NUM_CAND - 1)) ? 3'd0 : disp_idx + 3'd1;
      end else begin
        dwell_nxt = dwell + DW_W'(1);
        idx_nxt   = disp_idx;
      end
    end
  end

  always_comb begin
    led_sel = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (idx_nxt == 3'(i)) led_sel = tally[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_LOCKED;
      voter_ready <= 1'b0;
      vote_ack    <= 1'b0;
      sat         <= 1'b0;
      disp_idx    <= '0;
      dwell       <= '0;
      LEDs        <= 8'h00;
      for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
    end else begin
      state       <= state_nxt;
      voter_ready <= (state_nxt == S_ARMED);
      vote_ack    <= (state_nxt == S_ACK);
      sat         <= sat | sat_hit;
      disp_idx    <= idx_nxt;
      dwell       <= dwell_nxt;
      LEDs        <= (state_nxt == S_RESULT) ? 8'(led_sel) : 8'h00;
      for (int i = 0; i < NUM_CAND; i++) tally[i] <= tally_nxt[i];
    end
  end

endmodule
`default_nettype wire
